viterbi_deint_frame_sequencer: RTL and testbench

- Sits between the Viterbi decoder's hard-decision bit output and the deinterleaver's AXI4-Stream input.
- Collects decoded bits MSB-first into DATA_WIDTH-bit words.
- Frames the words into blocks of a configured length and marks the last word of each block with tlast, so the deinterleaver sees whole interleaver blocks.
- Configuration fields are driven from the AXI4-Lite register bank. Status fields are read back through the same bank.

---
 rtl/viterbi_deint_frame_sequencer.sv | 119 +++++++++++
 tb/tb_viterbi_deint_frame_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_deint_frame_sequencer.sv
// Packs Viterbi hard-decision bits MSB-first into DATA_WIDTH-bit words and frames
// them into blocks of cfg_frame_len words, with tlast on the final word of each block.
module viterbi_deint_frame_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cfg_enable,
    input  logic [LEN_W-1:0]      cfg_frame_len,
    input  logic                  cfg_abort,
    input  logic                  s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  frame_done,
    output logic [LEN_W-1:0]      frame_count,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [CNT_W-1:0]        bit_cnt;
    logic [LEN_W-1:0]        word_cnt;
    logic [LEN_W-1:0]        len_q;
    logic [LEN_W-1:0]        frame_cnt_q;
    logic                    done_q;
    logic                    busy_q;

    logic start;
    logic in_hs;
    logic out_hs;
    logic bit_last;
    logic word_last;

    assign start     = (state == IDLE) && cfg_enable && (cfg_frame_len != '0);
    assign in_hs     = (state == COLLECT) && s_axis_tvalid;
    assign out_hs    = (state == EMIT) && m_axis_tready;
    assign bit_last  = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
    assign word_last = (word_cnt == (len_q - LEN_W'(1)));

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: if (in_hs && bit_last) state_next = EMIT;
            EMIT:    if (out_hs) state_next = word_last ? IDLE : COLLECT;
            default: state_next = IDLE;
        endcase
        // Abort overrides every transition, including the final EMIT handshake.
        if (cfg_abort) state_next = IDLE;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state       <= IDLE;
            shift_q     <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            len_q       <= '0;
            frame_cnt_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
            done_q <= out_hs && word_last && !cfg_abort;
            if (cfg_abort) begin
                shift_q  <= '0;
                bit_cnt  <= '0;
                word_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            len_q    <= cfg_frame_len;
                            word_cnt <= '0;
                            bit_cnt  <= '0;
                        end
                    end
                    COLLECT: begin
                        if (in_hs) begin
                            shift_q <= {shift_q[DATA_WIDTH-2:0], s_axis_tdata};
                            bit_cnt <= bit_last ? '0 : bit_cnt + CNT_W'(1);
                        end
                    end
                    EMIT: begin
                        if (out_hs) begin
                            word_cnt <= word_cnt + LEN_W'(1);
                            if (word_last) frame_cnt_q <= frame_cnt_q + LEN_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign s_axis_tready = (state == COLLECT);
    assign m_axis_tvalid = (state == EMIT);
    assign m_axis_tdata  = shift_q;
    assign m_axis_tlast  = (state == EMIT) && word_last;
    assign frame_done    = done_q;
    assign frame_count   = frame_cnt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_viterbi_deint_frame_sequencer.sv
// Bench for viterbi_deint_frame_sequencer: a per-cycle frame-level reference model,
// a directed vector table, and hand-written multi-cycle corner-case sequences.
module tb_viterbi_deint_frame_sequencer;

    localparam int DW = 8;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_enable;
    logic [LW-1:0] cfg_frame_len;
    logic          cfg_abort;
    logic          s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic          frame_done;
    logic [LW-1:0] frame_count;
    logic          busy;

    // Small second instance used only to exercise the counter wrap quickly.
    logic          w_enable;
    logic [2:0]    w_len;
    logic          w_tdata;
    logic          w_tvalid;
    logic          w_s_ready;
    logic [1:0]    w_m_data;
    logic          w_m_valid;
    logic          w_m_ready;
    logic          w_last;
    logic          w_done;
    logic [2:0]    w_count;
    logic          w_busy;

    always #5 clk = ~clk;

    viterbi_deint_frame_sequencer #(.DATA_WIDTH(DW), .LEN_W(LW)) dut (
        .ACLK(clk), .ARESET(rst), .cfg_enable(cfg_enable), .cfg_frame_len(cfg_frame_len),
        .cfg_abort(cfg_abort), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .frame_done(frame_done),
        .frame_count(frame_count), .busy(busy)
    );

    viterbi_deint_frame_sequencer #(.DATA_WIDTH(2), .LEN_W(3)) dut_wrap (
        .ACLK(clk), .ARESET(rst), .cfg_enable(w_enable), .cfg_frame_len(w_len),
        .cfg_abort(1'b0), .s_axis_tdata(w_tdata), .s_axis_tvalid(w_tvalid),
        .s_axis_tready(w_s_ready), .m_axis_tdata(w_m_data), .m_axis_tvalid(w_m_valid),
        .m_axis_tready(w_m_ready), .m_axis_tlast(w_last), .frame_done(w_done),
        .frame_count(w_count), .busy(w_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timeout at %0t", name, $time);
    endtask

    // Reference model: frame state tracked as "bits held since last word" and
    // "words sent this frame", evaluated on the falling edge.
    bit            m_active = 0;
    int            m_nbits  = 0;
    int            m_words  = 0;
    int            m_len    = 0;
    logic [DW-1:0] m_word   = '0;
    bit            m_done   = 0;
    logic [LW-1:0] m_count  = '0;

    always @(negedge clk) begin
        bit exp_sr, exp_mv, exp_last;
        if (rst) begin
            m_active = 0; m_nbits = 0; m_words = 0; m_len = 0;
            m_word = '0; m_done = 0; m_count = '0;
        end else begin
            exp_sr   = m_active && (m_nbits < DW);
            exp_mv   = m_active && (m_nbits == DW);
            exp_last = exp_mv && (m_words == m_len - 1);
            check("s_tready", 32'(s_tready), 32'(exp_sr));
            check("m_tvalid", 32'(m_tvalid), 32'(exp_mv));
            check("busy", 32'(busy), 32'(m_active));
            check("frame_done", 32'(frame_done), 32'(m_done));
            check("frame_count", 32'(frame_count), 32'(m_count));
            if (exp_mv) begin
                check("m_tdata", 32'(m_tdata), 32'(m_word));
                check("m_tlast", 32'(m_tlast), 32'(exp_last));
            end
            m_done = 0;
            if (cfg_abort) begin
                m_active = 0; m_nbits = 0; m_words = 0;
            end else if (!m_active) begin
                if (cfg_enable && cfg_frame_len != 0) begin
                    m_active = 1; m_len = int'(cfg_frame_len); m_words = 0; m_nbits = 0;
                end
            end else if (exp_sr && s_tvalid) begin
                m_word = {m_word[DW-2:0], s_tdata};
                m_nbits++;
            end else if (exp_mv && m_tready) begin
                m_nbits = 0;
                m_words++;
                if (m_words == m_len) begin
                    m_active = 0;
                    m_done   = 1;
                    m_count  = m_count + 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int n = 0;
        s_tvalid = 1'b1;
        s_tdata  = b;
        while (!s_tready && n < 50) begin
            step();
            n++;
        end
        if (!s_tready) timeout("send_bit");
        step();
        s_tvalid = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w);
        for (int i = DW - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic get_word(output logic [DW-1:0] d, output logic l);
        int n = 0;
        m_tready = 1'b1;
        while (!m_tvalid && n < 100) begin
            step();
            n++;
        end
        if (!m_tvalid) timeout("get_word");
        d = m_tdata;
        l = m_tlast;
        step();
    endtask

    task automatic start_frame(input int len);
        int n = 0;
        cfg_frame_len = LW'(len);
        cfg_enable    = 1'b1;
        step();
        while (!busy && n < 20) begin
            step();
            n++;
        end
        if (!busy) timeout("start_frame");
        cfg_enable = 1'b0;
    endtask

    typedef struct {
        int            len;
        logic [0:DW-1] bits;      // bits[0] is sent first
        logic [DW-1:0] exp_word;
        logic          exp_last;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [DW-1:0] d, hold_d, r;
        logic          l, hold_l;
        logic [LW-1:0] cnt0;
        int            pulses;
        int            n;

        vecs[0] = '{2, 8'b1010_0001, 8'hA1, 1'b0};
        vecs[1] = '{2, 8'b1111_0000, 8'hF0, 1'b1};
        vecs[2] = '{3, 8'b0000_0001, 8'h01, 1'b0};
        vecs[3] = '{3, 8'b1000_0000, 8'h80, 1'b0};
        vecs[4] = '{3, 8'b0110_1001, 8'h69, 1'b1};

        rst = 1'b1; cfg_enable = 1'b0; cfg_frame_len = '0; cfg_abort = 1'b0;
        s_tdata = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
        w_enable = 1'b0; w_len = 3'd1; w_tdata = 1'b0; w_tvalid = 1'b0; w_m_ready = 1'b1;
        #12;
        check("rst_tvalid", 32'(m_tvalid), 0);
        check("rst_sready", 32'(s_tready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(frame_count), 0);
        check("rst_done", 32'(frame_done), 0);

        // Table: two back-to-back frames (len 2 then 3) with enable held high.
        cfg_frame_len = LW'(vecs[0].len);
        cfg_enable    = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_frame_len = LW'(vecs[i].len);
            for (int b = 0; b < DW; b++) send_bit(vecs[i].bits[b]);
            get_word(d, l);
            check("vec_word", 32'(d), 32'(vecs[i].exp_word));
            check("vec_last", 32'(l), 32'(vecs[i].exp_last));
            if (i == 4) cfg_enable = 1'b0;
        end
        step();
        check("table_count", 32'(frame_count), 2);

        // Backpressure on a single-word frame.
        start_frame(1);
        m_tready = 1'b0;
        send_word(8'h5C);
        hold_d = m_tdata;
        hold_l = m_tlast;
        check("bp_word", 32'(hold_d), 32'h5C);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(m_tvalid), 1);
            check("bp_data", 32'(m_tdata), 32'(hold_d));
            check("bp_last", 32'(m_tlast), 32'(hold_l));
            check("bp_sready", 32'(s_tready), 0);
            step();
        end
        m_tready = 1'b1;
        step();
        check("bp_taken", 32'(m_tvalid), 0);

        // Random input gaps and output backpressure; the model checks every word.
        for (int f = 0; f < 4; f++) begin
            start_frame(int'($urandom_range(1, 4)));
            n = 0;
            while (busy && n < 400) begin
                s_tvalid = 1'($urandom_range(0, 1));
                s_tdata  = 1'($urandom_range(0, 1));
                m_tready = ($urandom_range(0, 3) != 0);
                step();
                n++;
            end
            s_tvalid = 1'b0;
            m_tready = 1'b1;
            check("rand_frame_end", 32'(busy), 0);
        end
        step();
        check("rand_count", 32'(frame_count), 7);

        // Abort after 4 bits of word 2, then a clean single-word frame.
        cnt0 = frame_count;
        start_frame(2);
        send_word(8'h3E);
        for (int b = 0; b < 4; b++) send_bit(1'b1);
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        step();
        check("abort_count", 32'(frame_count), 32'(cnt0));
        r = 8'($urandom);
        start_frame(1);
        send_word(r);
        get_word(d, l);
        check("post_abort_word", 32'(d), 32'(r));
        check("post_abort_last", 32'(l), 1);

        // Abort on the same cycle as the final word's handshake.
        cnt0 = frame_count;
        start_frame(1);
        m_tready = 1'b0;
        send_word(8'h77);
        m_tready = 1'b1;
        cfg_abort = 1'b1;
        step();
        cfg_abort = 1'b0;
        step();
        step();
        check("abort_last_count", 32'(frame_count), 32'(cnt0));

        // Zero length never starts.
        cfg_frame_len = '0;
        cfg_enable = 1'b1;
        for (int c = 0; c < 10; c++) step();
        check("len0_busy", 32'(busy), 0);
        cfg_enable = 1'b0;

        // Length change mid-frame: still 3 words; next frame uses 1.
        start_frame(3);
        cfg_frame_len = LW'(1);
        for (int k = 0; k < 3; k++) begin
            send_word(8'(8'h10 + k));
            get_word(d, l);
            check("midchg_word", 32'(d), 32'(8'h10 + k));
            check("midchg_last", 32'(l), (k == 2) ? 1 : 0);
        end
        start_frame(1);
        send_word(8'hC3);
        get_word(d, l);
        check("len1_word", 32'(d), 32'hC3);
        check("len1_last", 32'(l), 1);

        // Asynchronous reset while a word is waiting in EMIT.
        start_frame(1);
        m_tready = 1'b0;
        send_word(8'h99);
        step();
        #2 rst = 1'b1;
        #1;
        check("arst_tvalid", 32'(m_tvalid), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_count", 32'(frame_count), 0);
        step();
        rst = 1'b0;
        m_tready = 1'b1;
        step();

        // Counter wrap on the 3-bit instance: 8 frames bring it back to 0.
        w_len = 3'd1;
        w_tvalid = 1'b1;
        w_enable = 1'b1;
        pulses = 0;
        n = 0;
        while (pulses < 8 && n < 200) begin
            step();
            if (w_done) begin
                pulses++;
                check("wrap_count", 32'(w_count), 32'(pulses % 8));
            end
            n++;
        end
        if (pulses < 8) timeout("wrap");
        w_enable = 1'b0;
        w_tvalid = 1'b0;
        for (int c = 0; c < 6; c++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
